// File: rtl/ssd_scan.sv
// ssd_scan - time-multiplexed scan controller for a four-digit common-anode
// seven-segment display.
//
// Steps through the four digits, DIV clock cycles per digit, driving one
// active-low anode at a time together with the matching nibble for an
// external hex-to-segment decoder. Supports a per-digit enable mask,
// leading-zero blanking, per-digit decimal points, a dead-time gap at the
// start of every slot, and value updates that only take effect on a frame
// boundary so a frame never shows a mix of old and new digits.
//
// Parameters:
//   DIV        clock cycles per digit slot (>= 2)
//   BLANK      cycles at the start of each slot with all anodes off (< DIV)
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   value      16-bit display value, nibble k -> digit k (digit 0 rightmost)
//   load       one-cycle strobe capturing value/dp_in/en_in/lzb
//   dp_in      decimal point request per digit (1 = lit)
//   en_in      digit enable mask (1 = digit may light)
//   lzb        leading-zero blanking enable
//   anode      active-low anode enables, at most one low
//   number     nibble of the currently scanned digit
//   dp         active-low decimal point segment
//   frame_done one-cycle pulse in the cycle after digit 3's slot ends

module ssd_scan #(
  parameter int DIV   = 50000,
  parameter int BLANK = 500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] value,
  input  logic        load,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  en_in,
  input  logic        lzb,
  output logic [3:0]  anode,
  output logic [3:0]  number,
  output logic        dp,
  output logic        frame_done
);

  localparam int PCW = $clog2(DIV);
  localparam logic [PCW-1:0] PC_LAST  = PCW'(DIV - 1);
  localparam logic [PCW-1:0] PC_BLANK = PCW'(BLANK);

  logic [PCW-1:0] pc_q, pc_d;
  logic [1:0]     idx_q, idx_d;

  logic [15:0]    sh_value_q, sh_value_d;
  logic [3:0]     sh_dp_q, sh_dp_d;
  logic [3:0]     sh_en_q, sh_en_d;
  logic           sh_lzb_q, sh_lzb_d;
  logic           pending_q, pending_d;

  logic [15:0]    act_value_q, act_value_d;
  logic [3:0]     act_dp_q, act_dp_d;
  logic [3:0]     act_en_q, act_en_d;
  logic           act_lzb_q, act_lzb_d;

  logic [3:0]     anode_q, anode_d;
  logic [3:0]     number_q, number_d;
  logic           dp_q, dp_d;
  logic           frame_done_q, frame_done_d;

  logic           tick;
  logic           boundary;
  logic [3:0]     lz_blank;
  logic           visible;

  // Next-state logic: prescaler, digit index, shadow/active value handoff,
  // and the registered display outputs derived from the current slot.
  always_comb begin
    tick     = (pc_q == PC_LAST);
    boundary = tick && (idx_q == 2'd3);

    pc_d  = tick ? '0 : pc_q + 1'b1;
    idx_d = tick ? idx_q + 2'd1 : idx_q;

    sh_value_d  = sh_value_q;
    sh_dp_d     = sh_dp_q;
    sh_en_d     = sh_en_q;
    sh_lzb_d    = sh_lzb_q;
    act_value_d = act_value_q;
    act_dp_d    = act_dp_q;
    act_en_d    = act_en_q;
    act_lzb_d   = act_lzb_q;
    pending_d   = pending_q;

    if (load) begin
      sh_value_d = value;
      sh_dp_d    = dp_in;
      sh_en_d    = en_in;
      sh_lzb_d   = lzb;
    end

    // A load landing exactly on the boundary bypasses the shadow so it is
    // shown in the very next frame rather than one frame later.
    if (boundary) begin
      if (load) begin
        act_value_d = value;
        act_dp_d    = dp_in;
        act_en_d    = en_in;
        act_lzb_d   = lzb;
      end else if (pending_q) begin
        act_value_d = sh_value_q;
        act_dp_d    = sh_dp_q;
        act_en_d    = sh_en_q;
        act_lzb_d   = sh_lzb_q;
      end
      pending_d = 1'b0;
    end else if (load) begin
      pending_d = 1'b1;
    end

    // A digit is a leading zero when it and every digit above it are zero;
    // the chain runs from the top down and never reaches digit 0.
    lz_blank[3] = act_lzb_q && (act_value_q[15:12] == 4'h0);
    lz_blank[2] = lz_blank[3] && (act_value_q[11:8] == 4'h0);
    lz_blank[1] = lz_blank[2] && (act_value_q[7:4] == 4'h0);
    lz_blank[0] = 1'b0;

    visible = act_en_q[idx_q] && !lz_blank[idx_q] && (pc_q >= PC_BLANK);

    anode_d = 4'b1111;
    if (visible) begin
      anode_d[idx_q] = 1'b0;
    end
    number_d     = act_value_q[{idx_q, 2'b00} +: 4];
    dp_d         = visible ? ~act_dp_q[idx_q] : 1'b1;
    frame_done_d = boundary;
  end

  // State and output registers with synchronous active-low reset; a load in
  // the reset cycle is simply lost because reset takes priority.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q         <= '0;
      idx_q        <= 2'd0;
      sh_value_q   <= 16'h0000;
      sh_dp_q      <= 4'h0;
      sh_en_q      <= 4'h0;
      sh_lzb_q     <= 1'b0;
      pending_q    <= 1'b0;
      act_value_q  <= 16'h0000;
      act_dp_q     <= 4'h0;
      act_en_q     <= 4'h0;
      act_lzb_q    <= 1'b0;
      anode_q      <= 4'b1111;
      number_q     <= 4'h0;
      dp_q         <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      idx_q        <= idx_d;
      sh_value_q   <= sh_value_d;
      sh_dp_q      <= sh_dp_d;
      sh_en_q      <= sh_en_d;
      sh_lzb_q     <= sh_lzb_d;
      pending_q    <= pending_d;
      act_value_q  <= act_value_d;
      act_dp_q     <= act_dp_d;
      act_en_q     <= act_en_d;
      act_lzb_q    <= act_lzb_d;
      anode_q      <= anode_d;
      number_q     <= number_d;
      dp_q         <= dp_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign anode      = anode_q;
  assign number     = number_q;
  assign dp         = dp_q;
  assign frame_done = frame_done_q;

endmodule
